// File: rtl/game_move_history_if.sv
// Move-history handshake bundle between the Sokoban game core (master)
// and the undo history LIFO (slave).
interface game_move_history_if #(parameter int ADDR_BITS = 4);
   logic                 push_valid;
   logic [1:0]           push_dir;
   logic                 push_box;
   logic                 undo_req;
   logic                 undo_valid;
   logic [1:0]           undo_dir;
   logic                 undo_box;
   logic                 undo_ack;
   logic                 step_inc;
   logic                 step_dec;
   logic [ADDR_BITS:0]   count;
   logic                 empty;
   logic                 full;

   modport master (
      output push_valid, push_dir, push_box, undo_req, undo_ack,
      input  undo_valid, undo_dir, undo_box, step_inc, step_dec, count, empty, full
   );

   modport slave (
      input  push_valid, push_dir, push_box, undo_req, undo_ack,
      output undo_valid, undo_dir, undo_box, step_inc, step_dec, count, empty, full
   );
endinterface

// File: rtl/game_move_history.sv
// Move-history LIFO for undo: records {dir, box} per move, pops on undo and
// emits step_inc/step_dec pulses to keep the step counter in lockstep.
//
// state  | meaning
// IDLE   | accepting pushes and undo requests
// REPLAY | popped record presented on undo_*, waiting for undo_ack
module game_move_history #(
   parameter int DEPTH     = 16,
   parameter int ADDR_BITS = 4
) (
   input logic               clk,
   input logic               rst,
   input logic               clr,
   game_move_history_if.slave bus
);
   typedef enum logic {IDLE, REPLAY} state_t;

   localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);

   logic [2:0]           mem [DEPTH];
   state_t               state, state_n;
   logic [ADDR_BITS-1:0] wp, wp_n, rd_addr;
   logic [ADDR_BITS:0]   count_q, count_n;
   logic                 valid_q, valid_n;
   logic [1:0]           dir_q, dir_n;
   logic                 box_q, box_n;
   logic                 inc_q, inc_n;
   logic                 dec_q, dec_n;
   logic                 empty_q, full_q;
   logic                 we;

   assign rd_addr = wp - ADDR_BITS'(1);

   always_comb begin
      state_n = state;
      wp_n    = wp;
      count_n = count_q;
      valid_n = valid_q;
      dir_n   = dir_q;
      box_n   = box_q;
      inc_n   = 1'b0;
      dec_n   = 1'b0;
      we      = 1'b0;
      case (state)
         IDLE: begin
            // push has priority; a full history overwrites its oldest entry
            if (bus.push_valid) begin
               we    = 1'b1;
               wp_n  = wp + ADDR_BITS'(1);
               inc_n = 1'b1;
               if (count_q != DEPTH_C)
                  count_n = count_q + (ADDR_BITS+1)'(1);
            end else if (bus.undo_req && count_q != '0) begin
               wp_n           = rd_addr;
               count_n        = count_q - (ADDR_BITS+1)'(1);
               {dir_n, box_n} = mem[rd_addr];
               valid_n        = 1'b1;
               dec_n          = 1'b1;
               state_n        = REPLAY;
            end
         end
         REPLAY: begin
            if (bus.undo_ack) begin
               valid_n = 1'b0;
               state_n = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state   <= IDLE;
         wp      <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         dir_q   <= '0;
         box_q   <= 1'b0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         state   <= state_n;
         wp      <= wp_n;
         count_q <= count_n;
         valid_q <= valid_n;
         dir_q   <= dir_n;
         box_q   <= box_n;
         inc_q   <= inc_n;
         dec_q   <= dec_n;
         empty_q <= (count_n == '0);
         full_q  <= (count_n == DEPTH_C);
      end
   end

   always_ff @(posedge clk) begin
      if (we && !rst && !clr)
         mem[wp] <= {bus.push_dir, bus.push_box};
   end

   assign bus.undo_valid = valid_q;
   assign bus.undo_dir   = dir_q;
   assign bus.undo_box   = box_q;
   assign bus.step_inc   = inc_q;
   assign bus.step_dec   = dec_q;
   assign bus.count      = count_q;
   assign bus.empty      = empty_q;
   assign bus.full       = full_q;
endmodule
